// File: rtl/avalon_mms_mem_responder_pkg.sv
// Shared constants, FSM state type and request decode for the Avalon-MM RAM responder.
package avalon_mms_mem_responder_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int unsigned DATA_NBIT = 32;
  localparam int unsigned LANES     = DATA_NBIT / 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic is_req(input logic cs, input logic rd_n, input logic wr_n);
    return cs & ((rd_n == LOW) | (wr_n == LOW));
  endfunction

endpackage

// File: rtl/avalon_mms_mem_responder_if.sv
// Avalon-MM bus bundle between a master (e.g. avalon2memwr) and the RAM responder.
interface avalon_mms_mem_responder_if #(
  parameter int unsigned P_ADDR_NBIT = 24
);
  logic [P_ADDR_NBIT-1:0] avalon_address;
  logic [3:0]             avalon_byteenable_n;
  logic                   avalon_chipselect;
  logic [31:0]            avalon_writedata;
  logic                   avalon_read_n;
  logic                   avalon_write_n;
  logic [31:0]            avalon_readdata;
  logic                   avalon_readdatavalid;
  logic                   avalon_waitrequest;

  modport master (
    output avalon_address, avalon_byteenable_n, avalon_chipselect,
           avalon_writedata, avalon_read_n, avalon_write_n,
    input  avalon_readdata, avalon_readdatavalid, avalon_waitrequest
  );

  modport slave (
    input  avalon_address, avalon_byteenable_n, avalon_chipselect,
           avalon_writedata, avalon_read_n, avalon_write_n,
    output avalon_readdata, avalon_readdatavalid, avalon_waitrequest
  );
endinterface

// File: rtl/avalon_mms_mem_responder_pipe_delay.sv
// Fixed-depth valid+data delay line; reset clears only the valid bits (MSB of each word).
module pipe_delay #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n;
    assign dout       = din;
  end else begin : g_pipe
    logic             vld [DEPTH];
    logic [WIDTH-2:0] dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) vld[i] <= 1'b0;
      end else begin
        vld[0] <= din[WIDTH-1];
        for (int unsigned i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat[0] <= din[WIDTH-2:0];
      for (int unsigned i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end

    assign dout = {vld[DEPTH-1], dat[DEPTH-1]};
  end

endmodule

// File: rtl/avalon_mms_mem_responder.sv
// Avalon-MM slave backed by byte-lane on-chip RAM: emulated init busy period,
// programmable post-accept wait states and fixed pipelined read latency.
module avalon_mms_mem_responder
  import avalon_mms_mem_responder_pkg::*;
#(
  parameter int unsigned P_ADDR_NBIT   = 24,
  parameter int unsigned P_MEM_AW      = 10,
  parameter int unsigned P_INIT_CYCLES = 100,
  parameter int unsigned P_WAIT        = 0,
  parameter int unsigned P_RD_LAT      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  avalon_mms_mem_responder_if.slave  bus,
  output logic                       err_proto
);

  localparam int unsigned INIT_NBIT = (P_INIT_CYCLES > 1) ? $clog2(P_INIT_CYCLES) : 1;
  localparam logic [INIT_NBIT-1:0] INIT_LAST = INIT_NBIT'(P_INIT_CYCLES - 1);
  localparam logic [3:0]           WAIT_LOAD = 4'(P_WAIT);

  state_t                 state, state_nxt;
  logic [INIT_NBIT-1:0]   init_cnt;
  logic [3:0]             wait_cnt;
  logic                   wait_req;
  logic                   req, accept, rd_acc, wr_acc;
  logic [P_MEM_AW-1:0]    mem_addr;
  logic                   addr_unused;

  logic                   ram_vld;
  logic [DATA_NBIT-1:0]   ram_q;
  logic [DATA_NBIT:0]     pipe_out;
  logic                   rd_valid;
  logic [DATA_NBIT-1:0]   rd_data;

  assign mem_addr    = bus.avalon_address[P_MEM_AW-1:0];
  assign addr_unused = ^bus.avalon_address[P_ADDR_NBIT-1:P_MEM_AW];

  assign req    = is_req(bus.avalon_chipselect, bus.avalon_read_n, bus.avalon_write_n);
  assign accept = req & (wait_req == LOW);
  assign wr_acc = accept & (bus.avalon_write_n == LOW);
  assign rd_acc = accept & (bus.avalon_read_n == LOW) & (bus.avalon_write_n == HIGH);

  // State register plus the init and wait-state counters it owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + INIT_NBIT'(1);
      if ((state == ST_READY) && accept) wait_cnt <= WAIT_LOAD;
      else if (state == ST_WAIT)         wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  if (init_cnt == INIT_LAST) state_nxt = ST_READY;
      ST_READY: if (accept && (P_WAIT != 0)) state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_cnt == 4'd1) state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    wait_req = HIGH;
    if (state == ST_READY) wait_req = LOW;
  end

  assign bus.avalon_waitrequest = wait_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_proto <= LOW;
    end else if (accept && (bus.avalon_read_n == LOW) && (bus.avalon_write_n == LOW)) begin
      err_proto <= HIGH;
    end
  end

  // One RAM per byte lane so each lane carries its own write enable
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [2**P_MEM_AW];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (wr_acc && (bus.avalon_byteenable_n[i] == LOW))
        mem[mem_addr] <= bus.avalon_writedata[8*i +: 8];
      if (rd_acc)
        q <= mem[mem_addr];
    end
  end

  assign ram_q = {g_lane[3].q, g_lane[2].q, g_lane[1].q, g_lane[0].q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_vld <= LOW;
    else        ram_vld <= rd_acc;
  end

  // RAM register + (P_RD_LAT-1) delay stages + output register = P_RD_LAT + 1 flops;
  // the RAM register loads on the accept edge itself, so valid lands P_RD_LAT edges later.
  pipe_delay #(
    .WIDTH (DATA_NBIT + 1),
    .DEPTH (P_RD_LAT - 1)
  ) u_pipe_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({ram_vld, ram_q}),
    .dout  (pipe_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= LOW;
      rd_data  <= '0;
    end else begin
      rd_valid <= pipe_out[DATA_NBIT];
      if (pipe_out[DATA_NBIT]) rd_data <= pipe_out[DATA_NBIT-1:0];
    end
  end

  assign bus.avalon_readdatavalid = rd_valid;
  assign bus.avalon_readdata      = rd_data;

endmodule

// File: tb/tb_avalon_mms_mem_responder.sv
// Self-checking bench: init timing, table vectors, streaming, protocol error, reset flush,
// wait-state pattern and a randomized run against a queue/array reference model.
module tb_avalon_mms_mem_responder;

  localparam int unsigned RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic err_a, err_b;

  avalon_mms_mem_responder_if #(.P_ADDR_NBIT(24)) ifa ();
  avalon_mms_mem_responder_if #(.P_ADDR_NBIT(24)) ifb ();

  avalon_mms_mem_responder #(
    .P_ADDR_NBIT(24), .P_MEM_AW(10), .P_INIT_CYCLES(100), .P_WAIT(0), .P_RD_LAT(RD_LAT)
  ) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa), .err_proto(err_a));

  avalon_mms_mem_responder #(
    .P_ADDR_NBIT(24), .P_MEM_AW(10), .P_INIT_CYCLES(4), .P_WAIT(2), .P_RD_LAT(RD_LAT)
  ) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb), .err_proto(err_b));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        is_rd;
    logic [23:0] addr;
    logic [3:0]  be_n;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rd_t;

  vec_t        vt [10];
  rd_t         rq [$];
  logic [31:0] ref_mem [1024];
  logic        model_err;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_a();
    ifa.avalon_chipselect = 1'b0; ifa.avalon_read_n = 1'b1; ifa.avalon_write_n = 1'b1;
    ifa.avalon_address = '0; ifa.avalon_byteenable_n = 4'hF; ifa.avalon_writedata = '0;
  endtask

  task automatic idle_b();
    ifb.avalon_chipselect = 1'b0; ifb.avalon_read_n = 1'b1; ifb.avalon_write_n = 1'b1;
    ifb.avalon_address = '0; ifb.avalon_byteenable_n = 4'hF; ifb.avalon_writedata = '0;
  endtask

  task automatic drive_a(input logic rd_n, input logic wr_n, input logic [23:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    ifa.avalon_chipselect = 1'b1; ifa.avalon_read_n = rd_n; ifa.avalon_write_n = wr_n;
    ifa.avalon_address = a; ifa.avalon_byteenable_n = be; ifa.avalon_writedata = wd;
  endtask

  // Single command on A; a read is checked for exact latency, single pulse and hold.
  task automatic apply_a(input vec_t v, input string tag);
    drive_a(~v.is_rd, v.is_rd, v.addr, v.be_n, v.wdata);
    check({tag, "_wait"}, ifa.avalon_waitrequest, 0);
    tick();
    idle_a();
    if (v.is_rd) begin
      tick();
      check({tag, "_early"}, ifa.avalon_readdatavalid, 0);
      tick();
      check({tag, "_valid"}, ifa.avalon_readdatavalid, 1);
      check({tag, "_data"}, ifa.avalon_readdata, v.exp);
      tick();
      check({tag, "_pulse"}, ifa.avalon_readdatavalid, 0);
      check({tag, "_hold"}, ifa.avalon_readdata, v.exp);
    end
  endtask

  // One randomized cycle on A with the reference model deciding the expected outputs.
  task automatic rnd_step(input logic cs, input logic rd_n, input logic wr_n,
                          input logic [23:0] a, input logic [3:0] be, input logic [31:0] wd);
    int unsigned idx;
    idx = a % 1024;
    drive_a(rd_n, wr_n, a, be, wd);
    ifa.avalon_chipselect = cs;
    check("rnd_wait", ifa.avalon_waitrequest, 0);
    if (cs && (!rd_n || !wr_n)) begin
      if (!wr_n) begin
        for (int b = 0; b < 4; b++)
          if (!be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        if (!rd_n) model_err = 1'b1;
      end else begin
        rq.push_back('{cyc + 1 + RD_LAT, ref_mem[idx]});
      end
    end
    tick();
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rnd_valid", ifa.avalon_readdatavalid, 1);
      check("rnd_data", ifa.avalon_readdata, rq[0].data);
      last_data = rq[0].data;
      void'(rq.pop_front());
    end else begin
      check("rnd_novalid", ifa.avalon_readdatavalid, 0);
      check("rnd_hold", ifa.avalon_readdata, last_data);
    end
    check("rnd_err", err_a, model_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned na, nb, k, op, lat;
    logic        saw, wr_seen, found;
    logic [31:0] bdata [4];

    vt[0] = '{1'b0, 24'h000010, 4'b0000, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b1, 24'h000010, 4'b1111, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b0, 24'h000020, 4'b0000, 32'h11223344, 32'h0};
    vt[3] = '{1'b0, 24'h000020, 4'b1010, 32'hAABBCCDD, 32'h0};
    vt[4] = '{1'b1, 24'h000020, 4'b1111, 32'h0,        32'h11BB33DD};
    vt[5] = '{1'b0, 24'h000000, 4'b0000, 32'hCAFEF00D, 32'h0};
    vt[6] = '{1'b1, 24'h000400, 4'b1111, 32'h0,        32'hCAFEF00D};
    vt[7] = '{1'b0, 24'h000400, 4'b0001, 32'h12345678, 32'h0};
    vt[8] = '{1'b1, 24'h000000, 4'b1111, 32'h0,        32'h1234560D};
    vt[9] = '{1'b0, 24'hFFF010, 4'b1111, 32'hFFFFFFFF, 32'h0};

    idle_a(); idle_b();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", ifa.avalon_readdata, 0);
    check("rst_valid", ifa.avalon_readdatavalid, 0);
    check("rst_wait", ifa.avalon_waitrequest, 1);
    check("rst_err", err_a, 0);

    // Init: a read is offered throughout and must never be served
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    drive_a(1'b0, 1'b1, 24'h000010, 4'hF, 32'h0);
    na = 0; nb = 0; saw = 1'b0;
    for (int unsigned n = 1; n <= 200; n++) begin
      tick();
      if (ifa.avalon_readdatavalid) saw = 1'b1;
      if (nb == 0 && !ifb.avalon_waitrequest) nb = n;
      if (!ifa.avalon_waitrequest) begin na = n; break; end
    end
    idle_a();
    check("init_len_a", na, 100);
    check("init_len_b", nb, 4);
    check("init_novalid", saw, 0);

    foreach (vt[i]) apply_a(vt[i], $sformatf("tbl%0d", i));
    apply_a('{1'b1, 24'h000010, 4'b1111, 32'h0, 32'hDEADBEEF}, "noop_rd");
    check("err_clean", err_a, 0);

    // Streaming reads of 0..7 after back-to-back writes
    for (int unsigned i = 0; i < 8; i++) begin
      drive_a(1'b1, 1'b0, 24'(i), 4'b0000, 32'hC0DE0000 + i * 32'h11);
      tick();
    end
    for (int unsigned t = 0; t < 12; t++) begin
      if (t < 8) drive_a(1'b0, 1'b1, 24'(t), 4'hF, 32'h0);
      else idle_a();
      tick();
      check($sformatf("strm%0d_valid", t), ifa.avalon_readdatavalid, (t >= 2 && t < 10));
      if (t >= 2 && t < 10)
        check($sformatf("strm%0d_data", t), ifa.avalon_readdata, 32'hC0DE0000 + (t - 2) * 32'h11);
    end

    // read_n and write_n both low: write only, sticky error
    drive_a(1'b0, 1'b0, 24'h000050, 4'b0000, 32'h5A5A5A5A);
    tick();
    idle_a();
    for (int unsigned t = 0; t < 4; t++) begin
      check("proto_novalid", ifa.avalon_readdatavalid, 0);
      tick();
    end
    check("proto_err", err_a, 1);
    apply_a('{1'b1, 24'h000050, 4'b1111, 32'h0, 32'h5A5A5A5A}, "proto_rd");

    // Randomized traffic against the reference model
    model_err = 1'b1;
    last_data = 32'h5A5A5A5A;
    for (int unsigned i = 0; i < 64; i++) rnd_step(1'b1, 1'b1, 1'b0, 24'(i), 4'b0000, $urandom);
    for (int unsigned i = 0; i < 400; i++) begin
      logic [23:0] a;
      a  = (24'($urandom) & 24'hFFFC00) | 24'($urandom_range(0, 63));
      op = $urandom_range(0, 9);
      rnd_step($urandom_range(0, 3) != 0, !(op <= 3 || op == 8), !(op >= 4 && op <= 8),
               a, 4'($urandom), $urandom);
    end
    for (int unsigned i = 0; i < 4; i++) rnd_step(1'b0, 1'b1, 1'b1, '0, 4'hF, '0);

    // Reset with two reads in flight
    drive_a(1'b0, 1'b1, 24'h000001, 4'hF, 32'h0);
    tick();
    drive_a(1'b0, 1'b1, 24'h000002, 4'hF, 32'h0);
    tick();
    idle_a();
    rst_a_n = 1'b0;
    check("rstmid_valid", ifa.avalon_readdatavalid, 0);
    tick(); tick();
    rst_a_n = 1'b1;
    for (int unsigned t = 0; t < 6; t++) begin
      tick();
      check("rstmid_novalid", ifa.avalon_readdatavalid, 0);
      check("rstmid_wait", ifa.avalon_waitrequest, 1);
    end

    // Wait-state device: master holds each write, accept every third cycle
    k = 0;
    for (int unsigned t = 0; t < 12; t++) begin
      wr_seen = ifb.avalon_waitrequest;
      check($sformatf("bpat%0d", t), wr_seen, (t % 3) != 0);
      if (k < 4) begin
        ifb.avalon_chipselect = 1'b1; ifb.avalon_read_n = 1'b1; ifb.avalon_write_n = 1'b0;
        ifb.avalon_address = 24'(k); ifb.avalon_byteenable_n = 4'b0000;
        ifb.avalon_writedata = 32'h0B0B0000 | k;
      end else begin
        idle_b();
      end
      tick();
      if (!wr_seen && k < 4) begin
        bdata[k] = 32'h0B0B0000 | k;
        k++;
      end
    end
    idle_b();
    check("b_wr_count", k, 4);

    for (int unsigned r = 0; r < 4; r++) begin
      ifb.avalon_chipselect = 1'b1; ifb.avalon_read_n = 1'b0; ifb.avalon_write_n = 1'b1;
      ifb.avalon_address = 24'(r);
      k = 0;
      while (ifb.avalon_waitrequest && k < 10) begin tick(); k++; end
      check("b_rd_accept", (k < 10), 1);
      tick();
      idle_b();
      found = 1'b0; lat = 0;
      for (int unsigned j = 1; j <= 6; j++) begin
        tick();
        if (ifb.avalon_readdatavalid) begin
          found = 1'b1; lat = j;
          check($sformatf("b_rd%0d_data", r), ifb.avalon_readdata, bdata[r]);
          break;
        end
      end
      check($sformatf("b_rd%0d_found", r), found, 1);
      check($sformatf("b_rd%0d_lat", r), lat, RD_LAT);
      while (ifb.avalon_waitrequest && k < 20) begin tick(); k++; end
    end
    check("b_err", err_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
